mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, giving the address width in bits.
REQ-002 The block SHALL have parameter DW, default 32, giving the data width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of ACCESS cycles before abort (legal range 2..255).
REQ-004 clk  in  1  The single clock; all state changes on its rising edge.
REQ-005 reset  in  1  Synchronous, active-high reset.
REQ-006 if_req  in  1  Instruction-fetch read request; held high until if_ack.
REQ-007 if_addr  in  AW  Fetch address.
REQ-008 if_rdata  out  DW  Registered fetched word.
REQ-009 if_ack  out  1  One-cycle fetch completion pulse.
REQ-010 dm_req  in  1  Data request; held high until dm_ack.
REQ-011 dm_we  in  1  Data write (1) or read (0).
REQ-012 dm_addr  in  AW  Data address.
REQ-013 dm_wdata  in  DW  Store data.
REQ-014 dm_be  in  4  Byte enables (4'b1111 for sw; one-hot for sb).
REQ-015 dm_rdata  out  DW  Registered load data.
REQ-016 dm_ack  out  1  One-cycle data completion pulse.
REQ-017 mem_req  out  1  Request to the shared memory.
REQ-018 mem_we  out  1  Memory write strobe.
REQ-019 mem_addr  out  AW  Memory address.
REQ-020 mem_wdata  out  DW  Memory write data.
REQ-021 mem_be  out  4  Memory byte enables.
REQ-022 mem_rdata  in  DW  Memory read data; valid only with mem_ack.
REQ-023 mem_ack  in  1  Memory completion strobe.
REQ-024 err  out  1  One-cycle timeout flag, coincident with the aborted requester's ack.
REQ-025 busy  out  1  High whenever the state is not IDLE.

Function
REQ-026 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-027 In IDLE with any request asserted, the block SHALL latch the winner's identity, address, we, wdata and be (fetch: we=0, be=4'b1111), and move to ACCESS at the next edge.
REQ-028 In ACCESS, mem_req SHALL be 1 and mem_we/mem_addr/mem_wdata/mem_be SHALL be driven only from the latched copies; otherwise mem_req=0 and mem_we=0.
REQ-029 In ACCESS, mem_ack=1 SHALL capture mem_rdata into the winner's rdata register (reads only) and move the FSM to RESP.
REQ-030 In RESP, the winner's ack SHALL be 1 for exactly one cycle, followed by an unconditional move to IDLE, giving one dead cycle so a still-held request is never re-granted.
REQ-031 With a zero-wait memory (mem_ack in the first ACCESS cycle), ack SHALL appear two cycles after req is first sampled high, and a new grant SHALL occur no earlier than cycle 3.
REQ-032 A 8-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ack; when it reaches TIMEOUT-1 without mem_ack, the FSM SHALL go to RESP with err=1, and the winner's rdata SHALL be written with 0.
REQ-033 mem_ack outside ACCESS SHALL be ignored.
REQ-034 Data writes SHALL leave dm_rdata unchanged; if_rdata and dm_rdata SHALL hold their value between accesses.
REQ-035 A request deasserted while ungranted SHALL be dropped without effect; input changes after the grant SHALL NOT affect the access in flight.

Reset
REQ-036 With reset=1 at an edge, the state SHALL become IDLE, the counter 0, the rdata registers 0, the last-grant register "instruction", and all outputs 0, with no ack or err issued for an access in flight.
REQ-037 Reset SHALL take precedence over mem_ack in the same cycle.

Configuration
REQ-038 When macro ARB_RR_EN is defined, simultaneous requests in IDLE SHALL go to the requester not granted last (round-robin; last-grant register updated at each grant).
REQ-039 When ARB_RR_EN is undefined, simultaneous requests SHALL always go to the data port (fixed priority), and the last-grant register SHALL be absent.

Verification
REQ-040 Fetch only: if_req=1, if_addr=0x00003000, mem_ack=1 one cycle after mem_req, mem_rdata=0x8C010004 -> if_ack in cycle 2, if_rdata=0x8C010004, err=0.
REQ-041 Store byte: dm_req=1, dm_we=1, dm_addr=0x10, dm_be=4'b0100, dm_wdata=0x00AB0000 -> mem_we=1, mem_be=4'b0100 for the whole ACCESS, dm_ack=1, dm_rdata unchanged.
REQ-042 Collision: if_req and dm_req both rise at cycle 0 and stay held -> without ARB_RR_EN, data served first then fetch; with ARB_RR_EN after reset, data first, and on the next collision, fetch first.
REQ-043 Timeout: dm read, mem_ack never asserted, TIMEOUT=16 -> dm_ack and err both high on the cycle after the 16th ACCESS cycle, dm_rdata=0, then IDLE.
REQ-044 Reset mid-access: reset=1 in the second ACCESS cycle while mem_ack=1 -> no ack, mem_req=0 next cycle, busy=0, and a stray mem_ack in IDLE produces no response.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory; ARB_RR_EN selects round-robin, else data has priority.
// Latency: grant at the IDLE edge, ACCESS until mem_ack or TIMEOUT cycles, one RESP cycle with ack, one dead IDLE cycle.
// Backpressure: requesters hold req until their ack; the memory stalls by withholding mem_ack.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  input  logic [3:0]    dm_be,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
  } hdr_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next_state;
  hdr_t          r_hdr;
  hdr_t          w_hdr_in;
  logic [7:0]    r_cnt;
  logic          r_gnt_dm;
  logic          r_timeout;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;
  logic          w_pick_dm;
  logic          w_grant;
  logic          w_done_ack;
  logic          w_done_to;
  logic          w_cnt_inc;

`ifdef ARB_RR_EN
  logic r_last_dm;

  // On a collision the port that did not win last time goes first.
  assign w_pick_dm = dm_req & (~if_req | ~r_last_dm);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_dm <= 1'b0;
    end else if (w_grant) begin
      r_last_dm <= w_pick_dm;
    end
  end
`else
  assign w_pick_dm = dm_req;
`endif

  // Fetches are always full-word reads.
  always_comb begin
    if (w_pick_dm) begin
      w_hdr_in.we    = dm_we;
      w_hdr_in.addr  = dm_addr;
      w_hdr_in.wdata = dm_wdata;
      w_hdr_in.be    = dm_be;
    end else begin
      w_hdr_in.we    = 1'b0;
      w_hdr_in.addr  = if_addr;
      w_hdr_in.wdata = '0;
      w_hdr_in.be    = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_done_ack   = 1'b0;
    w_done_to    = 1'b0;
    w_cnt_inc    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    if_ack       = 1'b0;
    dm_ack       = 1'b0;
    err          = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (if_req | dm_req) begin
          w_grant      = 1'b1;
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = r_hdr.we;
        mem_addr  = r_hdr.addr;
        mem_wdata = r_hdr.wdata;
        mem_be    = r_hdr.be;
        if (mem_ack) begin
          w_done_ack   = 1'b1;
          w_next_state = ST_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_done_to    = 1'b1;
          w_next_state = ST_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_RESP: begin
        // Always fall back to IDLE so a request still held this cycle is not re-granted.
        busy         = 1'b1;
        if_ack       = ~r_gnt_dm;
        dm_ack       = r_gnt_dm;
        err          = r_timeout;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hdr      <= '0;
      r_gnt_dm   <= 1'b0;
      r_timeout  <= 1'b0;
      r_cnt      <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_hdr     <= w_hdr_in;
        r_gnt_dm  <= w_pick_dm;
        r_timeout <= 1'b0;
        r_cnt     <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_done_to) begin
        r_timeout <= 1'b1;
      end
      // An aborted access returns zero; a completed write leaves rdata alone.
      if (w_done_to || (w_done_ack && !r_hdr.we)) begin
        if (r_gnt_dm) begin
          r_dm_rdata <= w_done_to ? '0 : mem_rdata;
        end else begin
          r_if_rdata <= w_done_to ? '0 : mem_rdata;
        end
      end
    end
  end

  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model (grant cycle + cycle arithmetic).
module tb_mem_arbiter;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [3:0]    dm_be = 4'b1111;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          err;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .busy(busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b1;

  // Transaction-level model: one transaction at most, described by its grant cycle
  // and the cycle its access ended (-1 while still waiting on memory).
  bit          m_have = 1'b0;
  bit          m_is_dm = 1'b0;
  bit          m_we = 1'b0;
  bit          m_to = 1'b0;
  bit          m_last_dm = 1'b0;
  int          m_t_grant = 0;
  int          m_t_end = -1;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_if_rd = '0;
  logic [31:0] m_dm_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit pick_dm(input bit ir, input bit dr, input bit last_dm);
    if (RR) return dr && (!ir || !last_dm);
    return dr;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_have    = 1'b0;
      m_to      = 1'b0;
      m_if_rd   = '0;
      m_dm_rd   = '0;
      m_last_dm = 1'b0;
    end else if (!m_have) begin
      if (if_req || dm_req) begin
        m_is_dm   = pick_dm(if_req, dm_req, m_last_dm);
        m_last_dm = m_is_dm;
        m_have    = 1'b1;
        m_t_grant = cyc;
        m_t_end   = -1;
        m_to      = 1'b0;
        m_we      = m_is_dm ? dm_we : 1'b0;
        m_addr    = m_is_dm ? dm_addr : if_addr;
        m_wdata   = m_is_dm ? dm_wdata : '0;
        m_be      = m_is_dm ? dm_be : 4'b1111;
      end
    end else if (m_t_end < 0) begin
      if (mem_ack) begin
        m_t_end = cyc;
        if (!m_we) begin
          if (m_is_dm) m_dm_rd = mem_rdata;
          else         m_if_rd = mem_rdata;
        end
      end else if (cyc - m_t_grant == TIMEOUT) begin
        m_t_end = cyc;
        m_to    = 1'b1;
        if (m_is_dm) m_dm_rd = '0;
        else         m_if_rd = '0;
      end
    end else begin
      m_have = 1'b0;
    end
    cyc++;
  end

  always @(posedge clk) begin : cmp
    bit acc;
    bit rsp;
    #1;
    if (chk_en) begin
      acc = m_have && (m_t_end < 0);
      rsp = m_have && (m_t_end >= 0);
      chk("busy", busy, m_have);
      chk("mem_req", mem_req, acc);
      chk("mem_we", mem_we, acc && m_we);
      if (acc) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_be", mem_be, m_be);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("if_ack", if_ack, rsp && !m_is_dm);
      chk("dm_ack", dm_ack, rsp && m_is_dm);
      chk("err", err, rsp && m_to);
      chk("if_rdata", if_rdata, m_if_rd);
      chk("dm_rdata", dm_rdata, m_dm_rd);
    end
  end

  task automatic do_reset();
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    step();
    reset = 1'b0;
  endtask

  bit mem_slow = 1'b0;

  initial begin
    // Reset state
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    reset = 1'b0;

    // Fetch with zero-wait memory
    if_req = 1'b1; if_addr = 32'h0000_3000;
    step();
    chk("fe_mem_req", mem_req, 1);
    chk("fe_mem_addr", mem_addr, 32'h0000_3000);
    chk("fe_mem_be", mem_be, 4'b1111);
    mem_ack = 1'b1; mem_rdata = 32'h8C01_0004;
    step();
    chk("fe_if_ack", if_ack, 1);
    chk("fe_err", err, 0);
    chk("fe_if_rdata", if_rdata, 32'h8C01_0004);
    if_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    step();
    chk("fe_dead_busy", busy, 0);

    // Store byte, one wait state
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_be = 4'b0100; dm_wdata = 32'h00AB_0000;
    step();
    chk("sb_mem_we", mem_we, 1);
    chk("sb_mem_be", mem_be, 4'b0100);
    chk("sb_mem_wdata", mem_wdata, 32'h00AB_0000);
    step();
    chk("sb_mem_we2", mem_we, 1);
    chk("sb_mem_be2", mem_be, 4'b0100);
    mem_ack = 1'b1;
    step();
    chk("sb_dm_ack", dm_ack, 1);
    chk("sb_dm_rdata", dm_rdata, 0);
    dm_req = 1'b0; mem_ack = 1'b0;
    step();

    // Data read, then timeout read
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; dm_be = 4'b1111;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    chk("rd_dm_rdata", dm_rdata, 32'h1234_5678);
    dm_req = 1'b0; mem_ack = 1'b0;
    step();
    dm_req = 1'b1; dm_addr = 32'h40;
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      chk("to_mem_req", mem_req, 1);
      chk("to_no_ack", dm_ack, 0);
    end
    step();
    chk("to_dm_ack", dm_ack, 1);
    chk("to_err", err, 1);
    chk("to_dm_rdata", dm_rdata, 0);
    dm_req = 1'b0;
    step();
    chk("to_idle", busy, 0);

    // Collision after reset, data re-requests immediately after its ack
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    step();
    chk("col1_addr", mem_addr, 32'h200);
    mem_ack = 1'b1; mem_rdata = 32'h0A0A_0A0A;
    step();
    chk("col1_dm_ack", dm_ack, 1);
    chk("col1_if_ack", if_ack, 0);
    dm_addr = 32'h300; mem_ack = 1'b0;
    step();
    chk("col_dead", busy, 0);
    step();
    chk("col2_addr", mem_addr, RR ? 32'h100 : 32'h300);
    mem_ack = 1'b1; mem_rdata = 32'h5555_0000;
    step();
    chk("col2_if_ack", if_ack, RR);
    chk("col2_dm_ack", dm_ack, !RR);
    if (RR) if_req = 1'b0; else dm_req = 1'b0;
    mem_ack = 1'b0;
    step();
    step();
    chk("col3_addr", mem_addr, RR ? 32'h300 : 32'h100);
    mem_ack = 1'b1;
    step();
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    step();

    // Reset in the second ACCESS cycle with mem_ack, then a stray ack in IDLE
    if_req = 1'b1; if_addr = 32'h500;
    step();
    step();
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    chk("rm_busy", busy, 0);
    chk("rm_mem_req", mem_req, 0);
    chk("rm_if_ack", if_ack, 0);
    reset = 1'b0; if_req = 1'b0;
    step();
    chk("rm_stray_ack", if_ack, 0);
    chk("rm_stray_busy", busy, 0);
    mem_ack = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 249) == 0);
      if (if_req && if_ack) if_req = 1'b0;
      if (if_req && !(m_have && !m_is_dm) && $urandom_range(0, 9) == 0) begin
        if_req = 1'b0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = $urandom;
      end
      if ($urandom_range(0, 3) == 0) if_addr = $urandom;
      if (dm_req && dm_ack) dm_req = 1'b0;
      if (dm_req && !(m_have && m_is_dm) && $urandom_range(0, 9) == 0) begin
        dm_req = 1'b0;
      end else if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1'b1;
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom;
        dm_wdata = $urandom;
        dm_be = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'(1 << $urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) begin
        dm_addr = $urandom;
        dm_wdata = $urandom;
        dm_we = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 39) == 0) mem_slow = !mem_slow;
      mem_ack = mem_req ? (!mem_slow && $urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      step();
    end

    reset = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
